// File: rtl/fetch_unit.sv
// Program-counter and instruction-register datapath for the SISC processor.
// Executes the control FSM's PC/IR commands and fetches instructions over a req/ack handshake.
module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic               busy,
    output logic               ir_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]    imm;
    logic [ADDR_W-1:0]    target;

    // The immediate comes from the IR as it stands before the edge, so a
    // branch issued alongside an IR load still uses the old instruction.
    assign imm    = ir_q[ADDR_W-1:0];
    assign target = br_sel ? imm : pc_q + imm;

    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = '0;
        end else if (pc_write) begin
            pc_d = pc_sel ? target : pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        unique case (state_q)
            IDLE: begin
                if (ir_load) begin
                    fetch_addr_d = pc_q;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            fetch_addr_q <= '0;
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
        end
    end

    assign busy      = (state_q == REQ);
    assign imem_req  = busy;
    assign imem_addr = fetch_addr_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[31:28];
    assign mm        = ir_q[27:24];
    assign ir_valid  = ir_valid_q;

endmodule
